multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore FSM that sequences a multi-cycle MIPS datapath: shared ALU, single unified memory, instruction register (IR), ALUOut register.
- Replaces the single-cycle opcode decoder. Drives every mux select and write enable per cycle from the current state and the IR opcode.
- Handshakes with memory through mem_ready.
- Counts retired instructions.

Parameters:
- OP_W, 6, opcode width (IR[31:26]).
- ALUOP_W, 3, width of the AluOp field sent to the ALU control block.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  OP_W  opcode from IR[31:26].
- mem_ready  in  1  memory has completed the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU Zflag (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load.
- MemToReg  out  1  write-back data select: 1 = memory data register, 0 = ALUOut.
- RegDst  out  1  destination register: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write enable.
- AluSrcA  out  1  ALU operand A: 0 = PC, 1 = register A.
- AluSrcB  out  2  ALU operand B: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- AluOp  out  ALUOP_W  000 = add, 001 = sub, 010 = use funct field.
- PCSource  out  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse, unsupported opcode.
- instr_done  out  1  one-cycle pulse, instruction retired.
- instr_count  out  CNT_W  retired-instruction count.
- state  out  4  current state, for debug.

Behaviour:
- Reset (rst=1 at clock edge): state <= FETCH, instr_count <= 0.
- While rst=1, all outputs are forced to 0 (all write enables and strobes low). Reset mid-instruction abandons the instruction; no partial write is issued after the reset edge.
- Outputs are a combinational function of state. The only exceptions are the mem_ready gating and the op-dependent signals listed under the states below.
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- States and outputs (any signal not listed is 0):
  - FETCH(0): MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=add, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): AluSrcA=0, AluSrcB=11, AluOp=add (precomputes the branch target into ALUOut). Dispatch on op:
    - lw or sw -> MEM_ADDR
    - R-type -> R_EXEC
    - beq -> BEQ
    - j -> JUMP
    - addi -> ADDI_EXEC
    - any other op -> FETCH, with illegal_op=1 this cycle and no retire.
  - MEM_ADDR(2): AluSrcA=1, AluSrcB=10, AluOp=add. Goes to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD(3): MemRead=1, IorD=1. Waits while mem_ready=0, then goes to MEM_WB.
  - MEM_WB(4): RegWrite=1, RegDst=0, MemToReg=1, instr_done=1. Goes to FETCH.
  - MEM_WR(5): MemWrite=1, IorD=1. Waits while mem_ready=0. When mem_ready=1: instr_done=1 and goes to FETCH.
  - R_EXEC(6): AluSrcA=1, AluSrcB=00, AluOp=func. Goes to R_WB.
  - R_WB(7): RegWrite=1, RegDst=1, MemToReg=0, instr_done=1. Goes to FETCH.
  - BEQ(8): AluSrcA=1, AluSrcB=00, AluOp=sub, PCWriteCond=1, PCSource=01, instr_done=1. Goes to FETCH.
  - JUMP(9): PCWrite=1, PCSource=10, instr_done=1. Goes to FETCH.
  - ADDI_EXEC(10): AluSrcA=1, AluSrcB=10, AluOp=add. Goes to ADDI_WB.
  - ADDI_WB(11): RegWrite=1, RegDst=0, MemToReg=0, instr_done=1. Goes to FETCH.
- Unused state codes 12-15 go to FETCH on the next clock with all outputs 0.
- Latency with zero memory wait (cycles from entering FETCH to retire):
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Each wait cycle with mem_ready=0 adds exactly 1 cycle.
- mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- instr_count increments by 1 on every clock edge where instr_done=1 and rst=0. It wraps from 2^CNT_W-1 to 0.
- op is sampled only in DECODE and MEM_ADDR. The IR must hold op stable from DECODE until retire.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC
  - AluSrcB and PCSource encodings
- Optional sub-module retire_counter holds the instr_count register and its wrap logic.
- The FSM next-state and output logic stay in multicycle_control.

Test Plan:
- Reset: rst=1 for 2 cycles with op=100011 and mem_ready=1 -> all outputs 0, state=0, instr_count=0. After release, first cycle shows MemRead=1, AluSrcB=01.
- lw, mem_ready always 1 -> state sequence 0,1,2,3,4. instr_done high only in cycle 5, with RegWrite=1 and MemToReg=1 in that cycle. instr_count=1.
- sw with mem_ready low for 3 cycles in MEM_WR -> MemWrite=1 held for 4 cycles. instr_done fires once, on the mem_ready=1 cycle. Total latency 7.
- beq, then j, then R-type back to back -> retire latencies 3, 3, 4. PCWriteCond=1 only in BEQ. PCSource=10 in JUMP. AluOp=010 in R_EXEC. instr_count=3.
- op=111111 -> illegal_op=1 in DECODE only, next state FETCH, no RegWrite/MemWrite/PCWrite, instr_count unchanged.
- rst asserted during MEM_WR with mem_ready=0 -> MemWrite=0 from that cycle onward, state=0 after the edge. Preloading instr_count to 2^32-1 and retiring one instruction -> instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BEQ       = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_ADD  = 3'b000;
    localparam logic [2:0] ALUOP_SUB  = 3'b001;
    localparam logic [2:0] ALUOP_FUNC = 3'b010;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter; wraps naturally at 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath. Outputs depend on the
// state, with mem_ready gating in the memory states and op used in DECODE/MEM_ADDR.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic [ALUOP_W-1:0] AluOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instr_count,
    output logic [3:0]         state
);

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        AluSrcA     = 1'b0;
        AluSrcB     = SRCB_REG;
        AluOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;
        state       = state_q;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                AluSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures PC+4 + (imm<<2) ahead of a possible beq
                AluSrcB = SRCB_IMM_SH2;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
                AluSrcA = 1'b1;
                AluOp   = ALUOP_FUNC;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                AluSrcA     = 1'b1;
                AluOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_ADDI_EXEC: begin
                AluSrcA = 1'b1;
                AluSrcB = SRCB_IMM;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset silences every strobe immediately, not only after the edge
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemToReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            AluSrcA     = 1'b0;
            AluSrcB     = '0;
            AluOp       = '0;
            PCSource    = '0;
            illegal_op  = 1'b0;
            instr_done  = 1'b0;
            state       = '0;
        end
    end

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire (
        .clk  (clk),
        .rst  (rst),
        .inc  (instr_done),
        .count(instr_count)
    );

endmodule
